instruction_mem_prog: RTL and testbench

INSTRUCTION_MEM_PROG -- requirements
Module: instruction_mem_prog

---
 rtl/instruction_mem_prog.sv | 156 +++++++++++++++
 tb/tb_instruction_mem_prog.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_mem_prog.sv
// instruction_mem_prog
//   Programmable instruction store with a registered fetch port.
//   After reset the whole array is swept to HALT_WORD, one entry per cycle
//   (INIT). It then serves fetches (RUN) until a halt opcode is presented on
//   the output, after which it freezes (HALTED) until flushed or reset.
//   Program loads are accepted in RUN and HALTED.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   pc           16-bit fetch address
//   fetch_en     fetch request; low stalls the output
//   flush        clears the output and returns HALTED to RUN
//   prog_we      program-load write strobe
//   prog_addr    16-bit load address
//   prog_data    load data
//   ready        high once the init sweep is done (RUN/HALTED)
//   instruction  registered fetched word
//   inst_valid   instruction carries a new fetch this cycle
//   oob          last fetch addressed pc >= DEPTH
//   halted       high in HALTED
//   fetch_cnt    saturating count of inst_valid pulses
module instruction_mem_prog #(
  parameter int                INST_W    = 9,
  parameter int                DEPTH     = 256,
  parameter logic [INST_W-1:0] HALT_WORD = 9'h1A0,
  parameter int                HALT_OP_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       pc,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [15:0]       prog_addr,
  input  logic [INST_W-1:0] prog_data,
  output logic              ready,
  output logic [INST_W-1:0] instruction,
  output logic              inst_valid,
  output logic              oob,
  output logic              halted,
  output logic [31:0]       fetch_cnt
);

  localparam int                   AW        = $clog2(DEPTH);
  // One extra bit so DEPTH = 65536 is representable as a bound.
  localparam logic [16:0]          DEPTH_EXT = 17'(DEPTH);
  localparam logic [HALT_OP_W-1:0] HALT_OP   = HALT_WORD[INST_W-1 -: HALT_OP_W];

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_r;
  logic [AW-1:0]     idx_r;
  logic [INST_W-1:0] mem_r [DEPTH];

  logic              pc_in_range_s;
  logic              wr_in_range_s;
  logic [AW-1:0]     pc_idx_s;
  logic [AW-1:0]     wr_idx_s;
  logic [INST_W-1:0] rd_word_s;
  logic              halt_seen_s;

  // Address decode, read mux and halt detection on the registered output.
  always_comb begin
    pc_in_range_s = ({1'b0, pc} < DEPTH_EXT);
    wr_in_range_s = ({1'b0, prog_addr} < DEPTH_EXT);
    pc_idx_s      = pc[AW-1:0];
    wr_idx_s      = prog_addr[AW-1:0];
    if (pc_in_range_s) begin
      rd_word_s = mem_r[pc_idx_s];
    end else begin
      rd_word_s = HALT_WORD;
    end
    halt_seen_s = inst_valid && (instruction[INST_W-1 -: HALT_OP_W] == HALT_OP);
  end

  // Storage array: init sweep in INIT, program loads otherwise. The fetch
  // register samples the old contents on the same edge (read-before-write).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_r == ST_INIT) begin
        mem_r[idx_r] <= HALT_WORD;
      end else if (prog_we && wr_in_range_s) begin
        mem_r[wr_idx_s] <= prog_data;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      idx_r       <= '0;
      ready       <= 1'b0;
      instruction <= '0;
      inst_valid  <= 1'b0;
      oob         <= 1'b0;
      halted      <= 1'b0;
      fetch_cnt   <= 32'd0;
    end else begin
      case (state_r)
        ST_INIT: begin
          idx_r <= idx_r + AW'(1);
          if (idx_r == AW'(DEPTH - 1)) begin
            state_r <= ST_RUN;
            ready   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            instruction <= '0;
            inst_valid  <= 1'b0;
            oob         <= 1'b0;
          end else if (halt_seen_s) begin
            // The halt word stays visible; no further fetch is taken.
            state_r    <= ST_HALTED;
            halted     <= 1'b1;
            inst_valid <= 1'b0;
          end else if (fetch_en) begin
            instruction <= rd_word_s;
            oob         <= !pc_in_range_s;
            inst_valid  <= 1'b1;
            if (fetch_cnt != 32'hFFFF_FFFF) begin
              fetch_cnt <= fetch_cnt + 32'd1;
            end
          end else begin
            inst_valid <= 1'b0;
          end
        end
        ST_HALTED: begin
          if (flush) begin
            state_r     <= ST_RUN;
            halted      <= 1'b0;
            instruction <= '0;
            inst_valid  <= 1'b0;
            oob         <= 1'b0;
          end else begin
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_INIT;
          idx_r      <= '0;
          ready      <= 1'b0;
          inst_valid <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_mem_prog.sv
module tb_instruction_mem_prog;

  localparam logic [8:0] HALT = 9'h1A0;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en, flush, prog_we;
  logic [15:0] pc, prog_addr;
  logic [8:0]  prog_data;
  logic        ready, inst_valid, oob, halted;
  logic [8:0]  instruction;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_mem_prog dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ready(ready), .instruction(instruction), .inst_valid(inst_valid),
    .oob(oob), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  // Reference model: an array for the store plus the visible output values.
  logic [8:0]  ref_mem [256];
  int          init_left;
  logic        m_ready, m_halted, m_valid, m_oob;
  logic [8:0]  m_instr;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [15:0] p, input logic fe, input logic fl,
                        input logic we, input logic [15:0] wa, input logic [8:0] wd);
    rst_n = r; pc = p; fetch_en = fe; flush = fl;
    prog_we = we; prog_addr = wa; prog_data = wd;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [8:0] rd;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = HALT;
      init_left = 256;
      m_ready = 1'b0; m_halted = 1'b0; m_valid = 1'b0; m_oob = 1'b0;
      m_instr = 9'h000; m_cnt = 32'd0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) m_ready = 1'b1;
    end else begin
      rd = (pc < 16'd256) ? ref_mem[pc[7:0]] : HALT;
      if (flush) begin
        m_instr = 9'h000; m_valid = 1'b0; m_oob = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
        m_valid = 1'b0;
      end else if (m_valid && (m_instr[8:4] == 5'b11010)) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (fetch_en) begin
        m_instr = rd; m_oob = (pc >= 16'd256); m_valid = 1'b1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_valid = 1'b0;
      end
      if (prog_we && (prog_addr < 16'd256)) ref_mem[prog_addr[7:0]] = prog_data;
    end
  endtask

  task automatic edge_cmp(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".ready"},  32'(ready),       32'(m_ready));
    chk({tag, ".halted"}, 32'(halted),      32'(m_halted));
    chk({tag, ".valid"},  32'(inst_valid),  32'(m_valid));
    chk({tag, ".oob"},    32'(oob),         32'(m_oob));
    chk({tag, ".instr"},  32'(instruction), 32'(m_instr));
    chk({tag, ".cnt"},    fetch_cnt,        m_cnt);
  endtask

  // Reset release followed by the full sweep; ready must rise on edge 256.
  task automatic init_sweep(input string tag);
    set_in(1'b1, 16'd0, 1'b1, 1'b0, 1'b1, 16'd1, 9'h0FF);
    for (int i = 1; i <= 256; i++) begin
      edge_cmp(tag);
      if (i == 255) chk({tag, ".ready_before"}, 32'(ready), 32'd0);
    end
    chk({tag, ".ready_at_256"}, 32'(ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] pc;
    logic        fe, fl, we;
    logic [15:0] wa;
    logic [8:0]  wd;
    logic [8:0]  e_instr;
    logic        e_valid, e_oob, e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [26];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          pc        fe    fl    we    wa        wd       instr   v     oob   h     cnt
    vecs[0]  = '{16'd5,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b1, 1'b0, 1'b0, 32'd1};
    vecs[1]  = '{16'd5,    1'b0, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b0, 1'b0, 1'b1, 32'd1};
    vecs[2]  = '{16'd5,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b0, 1'b0, 1'b1, 32'd1};
    vecs[3]  = '{16'd0,    1'b0, 1'b1, 1'b0, 16'd0,   9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 32'd1};
    vecs[4]  = '{16'd0,    1'b0, 1'b0, 1'b1, 16'd1,   9'h061, 9'h000, 1'b0, 1'b0, 1'b0, 32'd1};
    vecs[5]  = '{16'd0,    1'b0, 1'b0, 1'b1, 16'd2,   9'h090, 9'h000, 1'b0, 1'b0, 1'b0, 32'd1};
    vecs[6]  = '{16'd1,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h061, 1'b1, 1'b0, 1'b0, 32'd2};
    vecs[7]  = '{16'd2,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h090, 1'b1, 1'b0, 1'b0, 32'd3};
    vecs[8]  = '{16'd1,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h061, 1'b1, 1'b0, 1'b0, 32'd4};
    vecs[9]  = '{16'd2,    1'b0, 1'b0, 1'b0, 16'd0,   9'h000, 9'h061, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[10] = '{16'd2,    1'b0, 1'b0, 1'b0, 16'd0,   9'h000, 9'h061, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[11] = '{16'd2,    1'b0, 1'b0, 1'b0, 16'd0,   9'h000, 9'h061, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[12] = '{16'd2,    1'b1, 1'b1, 1'b0, 16'd0,   9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 32'd4};
    vecs[13] = '{16'd3,    1'b1, 1'b0, 1'b1, 16'd3,   9'h0AA, 9'h1A0, 1'b1, 1'b0, 1'b0, 32'd5};
    vecs[14] = '{16'd3,    1'b0, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b0, 1'b0, 1'b1, 32'd5};
    vecs[15] = '{16'd3,    1'b0, 1'b1, 1'b0, 16'd0,   9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 32'd5};
    vecs[16] = '{16'd3,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h0AA, 1'b1, 1'b0, 1'b0, 32'd6};
    vecs[17] = '{16'h0100, 1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b1, 1'b1, 1'b0, 32'd7};
    vecs[18] = '{16'd0,    1'b0, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b0, 1'b1, 1'b1, 32'd7};
    vecs[19] = '{16'd0,    1'b0, 1'b1, 1'b0, 16'd0,   9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 32'd7};
    vecs[20] = '{16'd0,    1'b0, 1'b0, 1'b1, 16'h0100, 9'h055, 9'h000, 1'b0, 1'b0, 1'b0, 32'd7};
    vecs[21] = '{16'd0,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b1, 1'b0, 1'b0, 32'd8};
    vecs[22] = '{16'd0,    1'b0, 1'b1, 1'b0, 16'd0,   9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 32'd8};
    vecs[23] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h1A0, 1'b1, 1'b1, 1'b0, 32'd9};
    vecs[24] = '{16'd0,    1'b0, 1'b1, 1'b0, 16'd0,   9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 32'd9};
    vecs[25] = '{16'd1,    1'b1, 1'b0, 1'b0, 16'd0,   9'h000, 9'h061, 1'b1, 1'b0, 1'b0, 32'd10};

    // Reset state, held for two edges with busy inputs.
    set_in(1'b0, 16'd1, 1'b1, 1'b1, 1'b1, 16'd1, 9'h0FF);
    edge_cmp("rst0");
    edge_cmp("rst1");
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.instr", 32'(instruction), 32'd0);
    init_sweep("init");

    // Directed table: halt, loads, back-to-back, stall, flush, RBW, oob.
    for (int i = 0; i < 26; i++) begin
      set_in(1'b1, vecs[i].pc, vecs[i].fe, vecs[i].fl, vecs[i].we, vecs[i].wa, vecs[i].wd);
      edge_cmp($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_instr", i),  32'(instruction), 32'(vecs[i].e_instr));
      chk($sformatf("vec%0d.t_valid", i),  32'(inst_valid),  32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.t_oob", i),    32'(oob),         32'(vecs[i].e_oob));
      chk($sformatf("vec%0d.t_halted", i), 32'(halted),      32'(vecs[i].e_halted));
      chk($sformatf("vec%0d.t_cnt", i),    fetch_cnt,        vecs[i].e_cnt);
    end

    // Reset mid-RUN with a fetch pending: all outputs zero.
    set_in(1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 9'h000);
    edge_cmp("midrun_rst");
    chk("midrun_rst.instr", 32'(instruction), 32'd0);
    chk("midrun_rst.cnt", fetch_cnt, 32'd0);
    // Partial sweep then reset again: the sweep must restart from scratch.
    set_in(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 9'h000);
    for (int i = 0; i < 100; i++) edge_cmp("partial");
    chk("partial.ready", 32'(ready), 32'd0);
    set_in(1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 9'h000);
    edge_cmp("midinit_rst");
    init_sweep("reinit");
    set_in(1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 16'd0, 9'h000);
    edge_cmp("reload");
    chk("reinit.mem1", 32'(instruction), 32'h1A0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic       r, fe, fl, we;
      logic [15:0] p, wa;
      r  = ($urandom_range(0, 399) != 0);
      p  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 7));
      wa = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 7));
      fe = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 19) == 0);
      we = ($urandom_range(0, 9) < 3);
      set_in(r, p, fe, fl, we, wa, 9'($urandom));
      edge_cmp("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
